// File: rtl/bcd_serial_addsub_ctrl.sv
// bcd_serial_addsub_ctrl: digit-serial packed-BCD add/subtract sequencer.
// One 4-bit BCD add/subtract slice is reused once per clock, from digit 0
// upward, with the inter-digit carry held in a register. Subtraction uses
// nine's complement of b with an initial carry of 1, which gives ten's
// complement. The final carry is 1 when there is no borrow.
// Optional build macro: BCD_INVALID_CHK_EN. When it is defined, a start
// with any non-BCD nibble in a or b completes at once with err=1.
module bcd_serial_addsub_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                carry,
  output logic                err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             c_q;
  logic [W-1:0]     a_q, b_q;
  logic             mode_q;
  logic [W-1:0]     result_q;
  logic             busy_q, done_q, carry_q, err_q;

  logic [3:0]       digit_d;
  logic             c_d;
  logic             accept;
  logic             bad_in;

  // One BCD digit slice. It returns {carry_out, digit}.
  function automatic logic [4:0] bcd_slice(input logic [3:0] ad,
                                           input logic [3:0] bd,
                                           input logic       sub,
                                           input logic       cin);
    logic [3:0] bi;
    logic [4:0] s;
    logic [4:0] t;
    bi = sub ? (4'd9 - bd) : bd;
    s  = {1'b0, ad} + {1'b0, bi} + {4'b0000, cin};
    t  = s - 5'd10;
    if (s > 5'd9) return {1'b1, t[3:0]};
    else          return {1'b0, s[3:0]};
  endfunction

`ifdef BCD_INVALID_CHK_EN
  // Returns 1 when any nibble of v is greater than 9.
  function automatic logic has_non_bcd(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction
`endif

  // Current digit through the shared slice, and invalid-operand detection.
  always_comb begin
    {c_d, digit_d} = bcd_slice(a_q[4*idx_q +: 4], b_q[4*idx_q +: 4], mode_q, c_q);
    accept = start && (state_q != RUN);
`ifdef BCD_INVALID_CHK_EN
    bad_in = has_non_bcd(a) || has_non_bcd(b);
`else
    bad_in = 1'b0;
`endif
  end

  // Operand latches. These are data only, so they have no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= a;
      b_q    <= b;
      mode_q <= mode;
    end
  end

  // Sequencer FSM with registered outputs and the digit-by-digit result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      c_q      <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, FIN: begin
          if (start) begin
            idx_q   <= '0;
            c_q     <= mode;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            if (bad_in) begin
              // Non-BCD operands skip RUN and complete at once with an error.
              state_q  <= FIN;
              done_q   <= 1'b1;
              err_q    <= 1'b1;
              result_q <= '0;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          result_q[4*idx_q +: 4] <= digit_d;
          c_q   <= c_d;
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            carry_q <= c_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign carry  = carry_q;
  assign err    = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub_ctrl.sv
// Directed testbench for bcd_serial_addsub_ctrl with DIGITS=4.
module tb_bcd_serial_addsub_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [15:0] a, b;
  logic        busy, done, carry, err;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  bcd_serial_addsub_ctrl #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry(carry), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time %0t, required finish)", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one start and observes the operation. done_at is measured in
  // cycles after the start edge and is -1 if done never rises.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic md,
                        output logic [15:0] res, output logic cy, output logic er,
                        output int done_at, output int busy_n,
                        output logic done_next, output logic [15:0] res_held);
    a = av; b = bv; mode = md; start = 1'b1;
    tick();
    start = 1'b0;
    done_at = -1; busy_n = 0; res = 'x; cy = 1'bx; er = 1'bx;
    for (int cyc = 1; cyc <= 20 && done_at < 0; cyc++) begin
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        done_at = cyc; res = result; cy = carry; er = err;
      end
      tick();
    end
    done_next = done;
    res_held  = result;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    repeat (3) tick();
    checks++; if ({busy, done, carry, err} !== 4'b0000) begin errors++;
      $display("FAIL reset_ctrl: got busy/done/carry/err=%b required 0000", {busy, done, carry, err}); end
    checks++; if (result !== 16'h0000) begin errors++;
      $display("FAIL reset_result: got %h required 0000", result); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    logic [15:0] r, rh; logic cy, er, dn; int dat, bn;
    run_op(16'h1234, 16'h5678, 1'b0, r, cy, er, dat, bn, dn, rh);
    checks++; if (dat !== 5) begin errors++; $display("FAIL add_latency: got %0d required 5", dat); end
    checks++; if (bn !== 4) begin errors++; $display("FAIL add_busy_cycles: got %0d required 4", bn); end
    checks++; if (r !== 16'h6912) begin errors++; $display("FAIL add_result: got %h required 6912", r); end
    checks++; if (cy !== 1'b0) begin errors++; $display("FAIL add_carry: got %b required 0", cy); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL add_err: got %b required 0", er); end
    checks++; if (dn !== 1'b0) begin errors++; $display("FAIL add_done_single: got %b required 0", dn); end
    checks++; if (rh !== 16'h6912) begin errors++; $display("FAIL add_result_held: got %h required 6912", rh); end
  endtask

  task automatic test_carry_ripple();
    logic [15:0] r, rh; logic cy, er, dn; int dat, bn;
    run_op(16'h9999, 16'h0001, 1'b0, r, cy, er, dat, bn, dn, rh);
    checks++; if (dat !== 5) begin errors++; $display("FAIL ripple_latency: got %0d required 5", dat); end
    checks++; if (r !== 16'h0000) begin errors++; $display("FAIL ripple_result: got %h required 0000", r); end
    checks++; if (cy !== 1'b1) begin errors++; $display("FAIL ripple_carry: got %b required 1", cy); end
  endtask

  task automatic test_sub();
    logic [15:0] r, rh; logic cy, er, dn; int dat, bn;
    run_op(16'h5000, 16'h1234, 1'b1, r, cy, er, dat, bn, dn, rh);
    checks++; if (r !== 16'h3766) begin errors++; $display("FAIL sub_pos_result: got %h required 3766", r); end
    checks++; if (cy !== 1'b1) begin errors++; $display("FAIL sub_pos_carry: got %b required 1", cy); end
    checks++; if (dat !== 5) begin errors++; $display("FAIL sub_pos_latency: got %0d required 5", dat); end
    run_op(16'h0123, 16'h0456, 1'b1, r, cy, er, dat, bn, dn, rh);
    checks++; if (r !== 16'h9667) begin errors++; $display("FAIL sub_neg_result: got %h required 9667", r); end
    checks++; if (cy !== 1'b0) begin errors++; $display("FAIL sub_neg_carry: got %b required 0", cy); end
  endtask

  task automatic test_back_to_back();
    int dat;
    // First op: 9950+0060 -> 0010, carry 1. A start pulsed while busy must be ignored.
    a = 16'h9950; b = 16'h0060; mode = 1'b0; start = 1'b1;
    tick();                                         // cycle T+1
    a = 16'h1111; b = 16'h2222; mode = 1'b1; start = 1'b1;
    tick();                                         // cycle T+2
    start = 1'b0;
    dat = -1;
    for (int cyc = 2; cyc <= 20 && dat < 0; cyc++) begin
      if (done === 1'b1) dat = cyc;
      else tick();
    end
    checks++; if (dat !== 5) begin errors++; $display("FAIL b2b_first_latency: got %0d required 5", dat); end
    checks++; if (result !== 16'h0010) begin errors++; $display("FAIL b2b_first_result: got %h required 0010", result); end
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL b2b_first_carry: got %b required 1", carry); end
    // Start during the done cycle: 0123-0456 -> 9667, carry 0.
    a = 16'h0123; b = 16'h0456; mode = 1'b1; start = 1'b1;
    tick();                                         // cycle T'+1
    start = 1'b0; a = 16'h9999; b = 16'h9999; mode = 1'b0;
    checks++; if ({busy, done} !== 2'b10) begin errors++;
      $display("FAIL b2b_second_accept: got busy/done=%b required 10", {busy, done}); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL b2b_carry_clear: got %b required 0", carry); end
    dat = -1;
    for (int cyc = 1; cyc <= 20 && dat < 0; cyc++) begin
      if (done === 1'b1) dat = cyc;
      else tick();
    end
    checks++; if (dat !== 5) begin errors++; $display("FAIL b2b_second_latency: got %0d required 5", dat); end
    checks++; if (result !== 16'h9667) begin errors++; $display("FAIL b2b_second_result: got %h required 9667", result); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL b2b_second_carry: got %b required 0", carry); end
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [15:0] r, rh; logic cy, er, dn; int dat, bn, dcount;
    a = 16'h1234; b = 16'h5678; mode = 1'b0; start = 1'b1;
    tick();                                         // T+1
    start = 1'b0;
    tick();                                         // T+2
    rst_n = 1'b0;
    tick();                                         // T+3, reset applied
    checks++; if ({busy, done, carry, err, result} !== 20'h0) begin errors++;
      $display("FAIL midreset_outputs: got busy/done/carry/err/result=%b%b%b%b/%h required all 0",
               busy, done, carry, err, result); end
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1 || busy === 1'b1) dcount++;
      tick();
    end
    checks++; if (dcount !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d active cycles required 0", dcount); end
    // Simultaneous start and reset: reset wins.
    a = 16'h0001; b = 16'h0001; start = 1'b1; rst_n = 1'b0;
    tick();
    start = 1'b0; rst_n = 1'b1;
    tick();
    checks++; if ({busy, done} !== 2'b00) begin errors++;
      $display("FAIL start_vs_reset: got busy/done=%b required 00", {busy, done}); end
    run_op(16'h0042, 16'h0058, 1'b0, r, cy, er, dat, bn, dn, rh);
    checks++; if (dat !== 5) begin errors++; $display("FAIL post_reset_latency: got %0d required 5", dat); end
    checks++; if (r !== 16'h0100) begin errors++; $display("FAIL post_reset_result: got %h required 0100", r); end
  endtask

  task automatic test_invalid();
    logic [15:0] r, rh; logic cy, er, dn; int dat, bn;
    run_op(16'h12A4, 16'h0001, 1'b0, r, cy, er, dat, bn, dn, rh);
`ifdef BCD_INVALID_CHK_EN
    checks++; if (dat !== 1) begin errors++; $display("FAIL invalid_latency: got %0d required 1", dat); end
    checks++; if (bn !== 0) begin errors++; $display("FAIL invalid_busy: got %0d required 0", bn); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL invalid_err: got %b required 1", er); end
    checks++; if (r !== 16'h0000) begin errors++; $display("FAIL invalid_result: got %h required 0000", r); end
    checks++; if (cy !== 1'b0) begin errors++; $display("FAIL invalid_carry: got %b required 0", cy); end
`else
    checks++; if (dat !== 5) begin errors++; $display("FAIL nochk_latency: got %0d required 5", dat); end
    checks++; if (bn !== 4) begin errors++; $display("FAIL nochk_busy: got %0d required 4", bn); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL nochk_err: got %b required 0", er); end
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry_ripple();
    test_sub();
    test_back_to_back();
    test_reset_mid();
    test_invalid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
